// File: rtl/frame_capture_pingpong.sv
// Ping-pong frame capture buffer: arms on go, stores one frame into the hidden bank, then swaps.
// Optional checksum of the last word against the sum of the others: define FRAME_RX_CHECKSUM_EN.
module frame_capture_pingpong #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 16,
  parameter int PACK      = 2,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_W-1:0]      rxd_i,
  input  logic                   rx_valid_i,
  input  logic                   frame_begin_i,
  input  logic                   go_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   frame_complete_o,
  output logic                   resync_err_o,
  output logic                   checksum_ok_o,
  output logic                   rd_bank_o,
  input  logic [ADDR_W-1:0]      read_addr_i,
  output logic [DATA_W*PACK-1:0] read_data_o,
  output logic [1:0]             state_o
);

  localparam int CNT_W    = $clog2(FRAME_LEN + 1);
  localparam int WA_W     = $clog2(FRAME_LEN);
  localparam int RD_WORDS = FRAME_LEN / PACK;
  localparam int RD_W     = DATA_W * PACK;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              frame_complete_q;
  logic              resync_err_q;
  logic              rd_bank_q;
  logic [RD_W-1:0]   read_data_q;

  logic [DATA_W-1:0] bank_q [2][FRAME_LEN];

  logic              wr_en;
  logic [WA_W-1:0]   wr_addr;
  logic              restart;
  logic              complete;
  logic [WA_W-1:0]   rd_idx;
  logic [RD_W-1:0]   rd_word_d;

  // Handshake: rxd_i and frame_begin_i are only meaningful in a cycle with rx_valid_i high;
  // there is no back-pressure, a valid word is consumed (or dropped) in the cycle it arrives.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = '0;
    restart  = 1'b0;
    complete = 1'b0;
    if (!abort_i && rx_valid_i) begin
      if (state_q == S_ARMED && frame_begin_i) begin
        wr_en   = 1'b1;
        restart = 1'b1;
      end else if (state_q == S_CAPT) begin
        wr_en = 1'b1;
        if (frame_begin_i) begin
          restart = 1'b1;
        end else begin
          wr_addr  = cnt_q[WA_W-1:0];
          complete = (cnt_q == LAST_IDX);
        end
      end
    end
  end

  // The write bank is always the one the reader is not looking at.
  always_ff @(posedge clk_i) begin
    if (wr_en) bank_q[~rd_bank_q][wr_addr] <= rxd_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      busy_q           <= 1'b0;
      frame_complete_q <= 1'b0;
      resync_err_q     <= 1'b0;
      rd_bank_q        <= 1'b0;
    end else begin
      frame_complete_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_i && !abort_i) begin
            state_q      <= S_ARMED;
            busy_q       <= 1'b1;
            resync_err_q <= 1'b0;
          end
        end
        S_ARMED: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (restart) begin
            state_q <= S_CAPT;
            cnt_q   <= CNT_W'(1);
          end
        end
        S_CAPT: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (restart) begin
            cnt_q        <= CNT_W'(1);
            resync_err_q <= 1'b1;
          end else if (complete) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            cnt_q            <= '0;
            frame_complete_q <= 1'b1;
            rd_bank_q        <= ~rd_bank_q;
          end else if (wr_en) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Lowest-addressed word lands in the MSBs of the packed read word.
  always_comb begin
    rd_word_d = '0;
    rd_idx    = '0;
    if (int'(read_addr_i) < RD_WORDS) begin
      for (int p = 0; p < PACK; p++) begin
        rd_idx = WA_W'(int'(read_addr_i) * PACK + p);
        rd_word_d[(PACK-1-p)*DATA_W +: DATA_W] = bank_q[rd_bank_q][rd_idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) read_data_q <= '0;
    else       read_data_q <= rd_word_d;
  end

`ifdef FRAME_RX_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              checksum_ok_q;

  // The running sum restarts on every word 0, so a resync discards the aborted prefix.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q         <= '0;
      checksum_ok_q <= 1'b1;
    end else if (restart) begin
      sum_q <= rxd_i;
    end else if (complete) begin
      checksum_ok_q <= (rxd_i == sum_q);
    end else if (wr_en) begin
      sum_q <= sum_q + rxd_i;
    end
  end

  assign checksum_ok_o = checksum_ok_q;
`else
  assign checksum_ok_o = 1'b1;
`endif

  assign busy_o           = busy_q;
  assign frame_complete_o = frame_complete_q;
  assign resync_err_o     = resync_err_q;
  assign rd_bank_o        = rd_bank_q;
  assign read_data_o      = read_data_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_frame_capture_pingpong.sv
// Directed bench for frame_capture_pingpong (FRAME_LEN=16, PACK=2, DATA_W=8).
module tb_frame_capture_pingpong;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 16;
  localparam int PACK      = 2;
  localparam int ADDR_W    = 8;
  localparam int RD_W      = DATA_W * PACK;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] rxd = '0;
  logic              rx_valid = 1'b0;
  logic              frame_begin = 1'b0;
  logic              go = 1'b0;
  logic              abort = 1'b0;
  logic              busy;
  logic              frame_complete;
  logic              resync_err;
  logic              checksum_ok;
  logic              rd_bank;
  logic [ADDR_W-1:0] read_addr = '0;
  logic [RD_W-1:0]   read_data;
  logic [1:0]        state;

  int n_vec  = 0;
  int n_err  = 0;
  int fc_cnt = 0;

  frame_capture_pingpong #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .PACK(PACK), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rxd_i(rxd), .rx_valid_i(rx_valid),
    .frame_begin_i(frame_begin), .go_i(go), .abort_i(abort),
    .busy_o(busy), .frame_complete_o(frame_complete), .resync_err_o(resync_err),
    .checksum_ok_o(checksum_ok), .rd_bank_o(rd_bank), .read_addr_i(read_addr),
    .read_data_o(read_data), .state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_complete === 1'b1) fc_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic fb);
    rxd = d; frame_begin = fb; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; frame_begin = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1; tick(); go = 1'b0;
  endtask

  task automatic read_word(input logic [7:0] a, output logic [RD_W-1:0] d);
    read_addr = a; tick(); d = read_data;
  endtask

  task automatic capture(input logic [7:0] base);
    pulse_go();
    for (int i = 0; i < FRAME_LEN; i++) send(base + 8'(i), i == 0);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_vec++; if (frame_complete !== 1'b0) begin n_err++; $display("FAIL rst_fc: got %0b want 0", frame_complete); end
    n_vec++; if (resync_err !== 1'b0) begin n_err++; $display("FAIL rst_resync: got %0b want 0", resync_err); end
    n_vec++; if (checksum_ok !== 1'b1) begin n_err++; $display("FAIL rst_ck: got %0b want 1", checksum_ok); end
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL rst_bank: got %0b want 0", rd_bank); end
    n_vec++; if (read_data !== 16'h0000) begin n_err++; $display("FAIL rst_rdata: got %h want 0000", read_data); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
    rst = 1'b0; tick();
  endtask

  task automatic test_single_frame();
    int fc0;
    logic [7:0]  addrs [5];
    logic [15:0] exps  [5];
    logic [15:0] d;
    logic        exp_ck;
    addrs = '{8'd0, 8'd3, 8'd7, 8'd8, 8'd255};
    exps  = '{16'h0102, 16'h0708, 16'h0F10, 16'h0000, 16'h0000};
    fc0 = fc_cnt;
    pulse_go();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL go_busy: got %0b want 1", busy); end
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL go_armed: got %0d want 1", state); end
    for (int i = 0; i < FRAME_LEN; i++) send(8'h01 + 8'(i), i == 0);
    n_vec++; if (frame_complete !== 1'b1) begin n_err++; $display("FAIL single_fc: got %0b want 1", frame_complete); end
    n_vec++; if (rd_bank !== 1'b1) begin n_err++; $display("FAIL single_bank: got %0b want 1", rd_bank); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %0b want 0", busy); end
`ifdef FRAME_RX_CHECKSUM_EN
    exp_ck = 1'b0;
`else
    exp_ck = 1'b1;
`endif
    n_vec++; if (checksum_ok !== exp_ck) begin n_err++; $display("FAIL single_ck: got %0b want %0b", checksum_ok, exp_ck); end
    tick();
    n_vec++; if (frame_complete !== 1'b0) begin n_err++; $display("FAIL single_fc_pulse: got %0b want 0", frame_complete); end
    n_vec++; if (fc_cnt - fc0 !== 1) begin n_err++; $display("FAIL single_fc_count: got %0d want 1", fc_cnt - fc0); end
    for (int k = 0; k < 5; k++) begin
      read_word(addrs[k], d);
      n_vec++; if (d !== exps[k]) begin n_err++; $display("FAIL single_read[%0d]: got %h want %h", addrs[k], d, exps[k]); end
    end
  endtask

  task automatic test_ping_pong();
    logic [15:0] d;
    pulse_go();
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), i == 0);
    read_word(8'd0, d);
    n_vec++; if (d !== 16'h0102) begin n_err++; $display("FAIL pp_mid_read0: got %h want 0102", d); end
    read_word(8'd7, d);
    n_vec++; if (d !== 16'h0F10) begin n_err++; $display("FAIL pp_mid_read7: got %h want 0F10", d); end
    for (int i = 8; i < FRAME_LEN - 1; i++) send(8'hA0 + 8'(i), 1'b0);
    read_addr = 8'd0;
    send(8'hAF, 1'b0);
    n_vec++; if (read_data !== 16'h0102) begin n_err++; $display("FAIL pp_swap_read: got %h want 0102", read_data); end
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL pp_bank: got %0b want 0", rd_bank); end
    tick();
    n_vec++; if (read_data !== 16'hA0A1) begin n_err++; $display("FAIL pp_read0: got %h want A0A1", read_data); end
    read_word(8'd7, d);
    n_vec++; if (d !== 16'hAEAF) begin n_err++; $display("FAIL pp_read7: got %h want AEAF", d); end
  endtask

  task automatic test_gaps_idle();
    int fc0;
    logic [15:0] d;
    fc0 = fc_cnt;
    for (int i = 0; i < FRAME_LEN; i++) send(8'h90 + 8'(i), i == 0);
    tick();
    n_vec++; if (fc_cnt - fc0 !== 0) begin n_err++; $display("FAIL idle_fc: got %0d want 0", fc_cnt - fc0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0b want 0", busy); end
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL idle_bank: got %0b want 0", rd_bank); end
    pulse_go();
    send(8'h55, 1'b0);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL armed_ignore: got %0d want 1", state); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      send(8'h20 + 8'(i), i == 0);
      if (i < FRAME_LEN - 1) begin
        rxd = 8'hFF; frame_begin = 1'b1; rx_valid = 1'b0;
        tick();
        frame_begin = 1'b0;
      end
    end
    tick();
    n_vec++; if (fc_cnt - fc0 !== 1) begin n_err++; $display("FAIL gaps_fc: got %0d want 1", fc_cnt - fc0); end
    n_vec++; if (rd_bank !== 1'b1) begin n_err++; $display("FAIL gaps_bank: got %0b want 1", rd_bank); end
    n_vec++; if (resync_err !== 1'b0) begin n_err++; $display("FAIL gaps_resync: got %0b want 0", resync_err); end
    read_word(8'd0, d);
    n_vec++; if (d !== 16'h2021) begin n_err++; $display("FAIL gaps_read0: got %h want 2021", d); end
    read_word(8'd5, d);
    n_vec++; if (d !== 16'h2A2B) begin n_err++; $display("FAIL gaps_read5: got %h want 2A2B", d); end
    read_word(8'd7, d);
    n_vec++; if (d !== 16'h2E2F) begin n_err++; $display("FAIL gaps_read7: got %h want 2E2F", d); end
  endtask

  task automatic test_resync_abort();
    int fc0;
    logic [15:0] d;
    fc0 = fc_cnt;
    pulse_go();
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), i == 0);
    n_vec++; if (resync_err !== 1'b0) begin n_err++; $display("FAIL resync_pre: got %0b want 0", resync_err); end
    send(8'h40, 1'b1);
    n_vec++; if (resync_err !== 1'b1) begin n_err++; $display("FAIL resync_set: got %0b want 1", resync_err); end
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL resync_state: got %0d want 2", state); end
    for (int i = 1; i < FRAME_LEN - 1; i++) send(8'h40 + 8'(i), 1'b0);
    n_vec++; if (fc_cnt - fc0 !== 0) begin n_err++; $display("FAIL resync_early_fc: got %0d want 0", fc_cnt - fc0); end
    send(8'h4F, 1'b0);
    n_vec++; if (frame_complete !== 1'b1) begin n_err++; $display("FAIL resync_fc: got %0b want 1", frame_complete); end
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL resync_bank: got %0b want 0", rd_bank); end
    read_word(8'd0, d);
    n_vec++; if (d !== 16'h4041) begin n_err++; $display("FAIL resync_read0: got %h want 4041", d); end
    read_word(8'd2, d);
    n_vec++; if (d !== 16'h4445) begin n_err++; $display("FAIL resync_read2: got %h want 4445", d); end
    n_vec++; if (resync_err !== 1'b1) begin n_err++; $display("FAIL resync_sticky: got %0b want 1", resync_err); end
    pulse_go();
    n_vec++; if (resync_err !== 1'b0) begin n_err++; $display("FAIL resync_clear: got %0b want 0", resync_err); end
    fc0 = fc_cnt;
    for (int i = 0; i < 9; i++) send(8'h60 + 8'(i), i == 0);
    abort = 1'b1; tick(); abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %0b want 0", busy); end
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL abort_bank: got %0b want 0", rd_bank); end
    pulse_go();
    for (int i = 0; i < FRAME_LEN - 1; i++) send(8'h70 + 8'(i), i == 0);
    abort = 1'b1; send(8'h7F, 1'b0); abort = 1'b0;
    n_vec++; if (frame_complete !== 1'b0) begin n_err++; $display("FAIL abort_prio_fc: got %0b want 0", frame_complete); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_prio_busy: got %0b want 0", busy); end
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL abort_prio_bank: got %0b want 0", rd_bank); end
    read_word(8'd0, d);
    n_vec++; if (d !== 16'h4041) begin n_err++; $display("FAIL abort_read0: got %h want 4041", d); end
    n_vec++; if (fc_cnt - fc0 !== 0) begin n_err++; $display("FAIL abort_fc_count: got %0d want 0", fc_cnt - fc0); end
    go = 1'b1; abort = 1'b1; tick(); go = 1'b0; abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL go_abort_idle: got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int fc0;
    logic [15:0] d;
    fc0 = fc_cnt;
    capture(8'hB0);
    n_vec++; if (frame_complete !== 1'b1) begin n_err++; $display("FAIL b2b_fc: got %0b want 1", frame_complete); end
    n_vec++; if (rd_bank !== 1'b1) begin n_err++; $display("FAIL b2b_bank1: got %0b want 1", rd_bank); end
    go = 1'b1; tick(); go = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_go: got %0b want 1", busy); end
    for (int i = 0; i < FRAME_LEN; i++) send(8'hC0 + 8'(i), i == 0);
    tick();
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL b2b_bank0: got %0b want 0", rd_bank); end
    n_vec++; if (fc_cnt - fc0 !== 2) begin n_err++; $display("FAIL b2b_fc_count: got %0d want 2", fc_cnt - fc0); end
    read_word(8'd0, d);
    n_vec++; if (d !== 16'hC0C1) begin n_err++; $display("FAIL b2b_read0: got %h want C0C1", d); end
  endtask

  task automatic test_checksum();
    logic [15:0] d;
    logic        exp_ck;
    pulse_go();
    for (int i = 0; i < FRAME_LEN - 1; i++) send(8'h01 + 8'(i), i == 0);
    send(8'h78, 1'b0);
    n_vec++; if (checksum_ok !== 1'b1) begin n_err++; $display("FAIL ck_good: got %0b want 1", checksum_ok); end
    n_vec++; if (rd_bank !== 1'b1) begin n_err++; $display("FAIL ck_good_bank: got %0b want 1", rd_bank); end
    pulse_go();
    for (int i = 0; i < FRAME_LEN - 1; i++) send(8'h01 + 8'(i), i == 0);
    send(8'h00, 1'b0);
`ifdef FRAME_RX_CHECKSUM_EN
    exp_ck = 1'b0;
`else
    exp_ck = 1'b1;
`endif
    n_vec++; if (checksum_ok !== exp_ck) begin n_err++; $display("FAIL ck_bad: got %0b want %0b", checksum_ok, exp_ck); end
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL ck_bad_bank: got %0b want 0", rd_bank); end
    read_word(8'd7, d);
    n_vec++; if (d !== 16'h0F00) begin n_err++; $display("FAIL ck_read7: got %h want 0F00", d); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    capture(8'hD0);
    pulse_go();
    send(8'hE0, 1'b1); send(8'hE1, 1'b0); send(8'hE2, 1'b1);
    for (int i = 3; i < 7; i++) send(8'hE0 + 8'(i), 1'b0);
    read_word(8'd0, d);
    n_vec++; if (d !== 16'hD0D1) begin n_err++; $display("FAIL mid_pre_read: got %h want D0D1", d); end
    n_vec++; if (resync_err !== 1'b1) begin n_err++; $display("FAIL mid_pre_resync: got %0b want 1", resync_err); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %0b want 0", busy); end
    n_vec++; if (frame_complete !== 1'b0) begin n_err++; $display("FAIL mid_fc: got %0b want 0", frame_complete); end
    n_vec++; if (resync_err !== 1'b0) begin n_err++; $display("FAIL mid_resync: got %0b want 0", resync_err); end
    n_vec++; if (rd_bank !== 1'b0) begin n_err++; $display("FAIL mid_bank: got %0b want 0", rd_bank); end
    n_vec++; if (checksum_ok !== 1'b1) begin n_err++; $display("FAIL mid_ck: got %0b want 1", checksum_ok); end
    n_vec++; if (read_data !== 16'h0000) begin n_err++; $display("FAIL mid_rdata: got %h want 0000", read_data); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL mid_state: got %0d want 0", state); end
    tick(); rst = 1'b0; tick();
    capture(8'h11);
    n_vec++; if (rd_bank !== 1'b1) begin n_err++; $display("FAIL post_rst_bank: got %0b want 1", rd_bank); end
    read_word(8'd0, d);
    n_vec++; if (d !== 16'h1112) begin n_err++; $display("FAIL post_rst_read0: got %h want 1112", d); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_single_frame();
    test_ping_pong();
    test_gaps_idle();
    test_resync_abort();
    test_back_to_back();
    test_checksum();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
